// File: rtl/ghost_renderer.sv
// Ghost sprite renderer: registers the RGB332 color of the next pixel from the VGA counters and
// bounces a 2-frame animated 16x16 sprite (scaled by SCALE) once per frame during blanking.
module ghost_renderer #(
    parameter int unsigned SCALE       = 2,
    parameter int unsigned SPEED_X     = 2,
    parameter int unsigned SPEED_Y     = 1,
    parameter int unsigned ANIM_FRAMES = 15,
    parameter logic [7:0]  BG_COLOR    = 8'h03,
    parameter logic [7:0]  BODY_COLOR  = 8'hE0,
    parameter logic [7:0]  EYE_COLOR   = 8'hFF
) (
    input  logic       i_vgaclk,
    input  logic       i_rst_n,
    input  logic [9:0] i_hc,
    input  logic [9:0] i_vc,
    input  logic       i_pause,
    output logic [2:0] o_red,
    output logic [2:0] o_green,
    output logic [1:0] o_blue,
    output logic [9:0] o_ghost_x,
    output logic [9:0] o_ghost_y,
    output logic       o_anim_frame
);
    localparam logic [10:0] SprSize = 11'(16 * SCALE);
    localparam logic [10:0] MaxX    = 11'(640 - 16 * SCALE);
    localparam logic [10:0] MaxY    = 11'(480 - 16 * SCALE);
    localparam logic [10:0] StepX   = 11'(SPEED_X);
    localparam logic [10:0] StepY   = 11'(SPEED_Y);
    localparam logic [10:0] Scale11 = 11'(SCALE);
    localparam int unsigned CntW    = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ANIM_FRAMES - 1);

    logic [9:0]      r_gx, r_gy;
    logic            r_dir_x, r_dir_y;  // 1 = moving toward 0
    logic [CntW-1:0] r_anim_cnt;
    logic            r_anim_frame;
    logic [7:0]      r_color;

    logic [10:0]     w_nh, w_nv, w_gx11, w_gy11, w_dx, w_dy;
    logic [3:0]      w_col, w_row;
    logic            w_in_box;
    logic [1:0]      w_code;
    logic [7:0]      w_color;
    logic            w_strobe;
    logic [10:0]     w_gx_nxt, w_gy_nxt;
    logic            w_dir_x_nxt, w_dir_y_nxt;

    function automatic logic [1:0] rom_px(input logic frame, input logic [3:0] row,
                                          input logic [3:0] col);
        logic [1:0] px;
        px = 2'd1;
        case (row)
            4'd0: px = (col >= 4'd5 && col <= 4'd10) ? 2'd1 : 2'd0;
            4'd5, 4'd6: begin
                if (col == 4'd4 || col == 4'd5 || col == 4'd10 || col == 4'd11) begin
                    px = 2'd2;
                    // Pupils shift left by one column in frame 1
                    if (row == 4'd6 && (frame ? (col == 4'd4 || col == 4'd10)
                                              : (col == 4'd5 || col == 4'd11))) begin
                        px = 2'd3;
                    end
                end
            end
            4'd8: px = (col == 4'd0 || col == 4'd15) ? 2'd0 : 2'd1;
            4'd13, 4'd14, 4'd15: px = (col[0] == frame) ? 2'd1 : 2'd0;
            default: px = 2'd1;
        endcase
        return px;
    endfunction

    always_comb begin
        w_nh = (i_hc == 10'd799) ? 11'd0 : {1'b0, i_hc} + 11'd1;
        if (i_hc == 10'd799) begin
            w_nv = (i_vc == 10'd524) ? 11'd0 : {1'b0, i_vc} + 11'd1;
        end else begin
            w_nv = {1'b0, i_vc};
        end
        w_gx11   = {1'b0, r_gx};
        w_gy11   = {1'b0, r_gy};
        w_dx     = w_nh - w_gx11;
        w_dy     = w_nv - w_gy11;
        w_col    = 4'(w_dx / Scale11);
        w_row    = 4'(w_dy / Scale11);
        w_in_box = (w_nh >= w_gx11) && (w_dx < SprSize) && (w_nv >= w_gy11) && (w_dy < SprSize);
        w_code   = rom_px(r_anim_frame, w_row, w_col);
        w_color  = 8'h00;
        if (w_nh < 11'd640 && w_nv < 11'd480) begin
            w_color = BG_COLOR;
            if (w_in_box) begin
                case (w_code)
                    2'd1:    w_color = BODY_COLOR;
                    2'd2:    w_color = EYE_COLOR;
                    2'd3:    w_color = 8'h03;
                    default: w_color = BG_COLOR;
                endcase
            end
        end
    end

    // Motion happens only on the first blanking line so a visible frame never tears
    assign w_strobe = (i_hc == 10'd0) && (i_vc == 10'd480) && !i_pause;

    always_comb begin
        w_gx_nxt    = w_gx11;
        w_dir_x_nxt = r_dir_x;
        if (!r_dir_x) begin
            if (w_gx11 + StepX >= MaxX) begin
                w_gx_nxt    = MaxX;
                w_dir_x_nxt = 1'b1;
            end else begin
                w_gx_nxt = w_gx11 + StepX;
            end
        end else if (w_gx11 <= StepX) begin
            w_gx_nxt    = 11'd0;
            w_dir_x_nxt = 1'b0;
        end else begin
            w_gx_nxt = w_gx11 - StepX;
        end

        w_gy_nxt    = w_gy11;
        w_dir_y_nxt = r_dir_y;
        if (!r_dir_y) begin
            if (w_gy11 + StepY >= MaxY) begin
                w_gy_nxt    = MaxY;
                w_dir_y_nxt = 1'b1;
            end else begin
                w_gy_nxt = w_gy11 + StepY;
            end
        end else if (w_gy11 <= StepY) begin
            w_gy_nxt    = 11'd0;
            w_dir_y_nxt = 1'b0;
        end else begin
            w_gy_nxt = w_gy11 - StepY;
        end
    end

    always_ff @(posedge i_vgaclk) begin
        if (!i_rst_n) begin
            r_gx         <= 10'd0;
            r_gy         <= 10'd0;
            r_dir_x      <= 1'b0;
            r_dir_y      <= 1'b0;
            r_anim_cnt   <= '0;
            r_anim_frame <= 1'b0;
            r_color      <= 8'h00;
        end else begin
            r_color <= w_color;
            if (w_strobe) begin
                r_gx    <= w_gx_nxt[9:0];
                r_gy    <= w_gy_nxt[9:0];
                r_dir_x <= w_dir_x_nxt;
                r_dir_y <= w_dir_y_nxt;
                if (r_anim_cnt == CntLast) begin
                    r_anim_cnt   <= '0;
                    r_anim_frame <= ~r_anim_frame;
                end else begin
                    r_anim_cnt <= r_anim_cnt + 1'b1;
                end
            end
        end
    end

    assign o_red        = r_color[7:5];
    assign o_green      = r_color[4:2];
    assign o_blue       = r_color[1:0];
    assign o_ghost_x    = r_gx;
    assign o_ghost_y    = r_gy;
    assign o_anim_frame = r_anim_frame;
endmodule

// File: tb/tb_ghost_renderer.sv
// Bench for ghost_renderer: directed steps plus random strobes/pixels checked against a
// behavioural model of the sprite, bounce and animation rules.
module tb_ghost_renderer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hc, vc;
    logic       pause;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic [9:0] gx_o, gy_o;
    logic       anim_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int m_gx, m_gy, m_dx, m_dy, m_cnt, m_frame, m_color;

    always #5 clk = ~clk;

    ghost_renderer dut (
        .i_vgaclk    (clk),
        .i_rst_n     (rst_n),
        .i_hc        (hc),
        .i_vc        (vc),
        .i_pause     (pause),
        .o_red       (red),
        .o_green     (green),
        .o_blue      (blue),
        .o_ghost_x   (gx_o),
        .o_ghost_y   (gy_o),
        .o_anim_frame(anim_o)
    );

    function automatic int sprite_code(int frame, int row, int col);
        if (row == 0) return (col >= 5 && col <= 10) ? 1 : 0;
        if (row == 5 || row == 6) begin
            if (row == 6 && frame == 0 && (col == 5 || col == 11)) return 3;
            if (row == 6 && frame == 1 && (col == 4 || col == 10)) return 3;
            if (col == 4 || col == 5 || col == 10 || col == 11) return 2;
            return 1;
        end
        if (row == 8) return (col == 0 || col == 15) ? 0 : 1;
        if (row >= 13) return ((col % 2) == frame) ? 1 : 0;
        return 1;
    endfunction

    function automatic int pixel_color(int h, int v, int gx, int gy, int frame);
        int nh, nv, code;
        nh = (h == 799) ? 0 : h + 1;
        nv = (h == 799) ? ((v == 524) ? 0 : v + 1) : v;
        if (nh >= 640 || nv >= 480) return 0;
        if (nh >= gx && nh < gx + 32 && nv >= gy && nv < gy + 32) begin
            code = sprite_code(frame, (nv - gy) / 2, (nh - gx) / 2);
            case (code)
                1: return 'hE0;
                2: return 'hFF;
                default: return 'h03;
            endcase
        end
        return 'h03;
    endfunction

    task automatic model_reset();
        m_gx = 0; m_gy = 0; m_dx = 1; m_dy = 1; m_cnt = 0; m_frame = 0; m_color = 0;
    endtask

    task automatic model_strobe();
        if (m_dx > 0) begin
            if (m_gx + 2 >= 608) begin m_gx = 608; m_dx = -1; end else m_gx += 2;
        end else begin
            if (m_gx <= 2) begin m_gx = 0; m_dx = 1; end else m_gx -= 2;
        end
        if (m_dy > 0) begin
            if (m_gy + 1 >= 448) begin m_gy = 448; m_dy = -1; end else m_gy += 1;
        end else begin
            if (m_gy <= 1) begin m_gy = 0; m_dy = 1; end else m_gy -= 1;
        end
        m_cnt++;
        if (m_cnt == 15) begin m_cnt = 0; m_frame = 1 - m_frame; end
    endtask

    // One clock with the inputs currently driven; model follows the same edge
    task automatic tick();
        if (!rst_n) model_reset();
        else begin
            m_color = pixel_color(int'(hc), int'(vc), m_gx, m_gy, m_frame);
            if (hc == 0 && vc == 480 && !pause) model_strobe();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, int obs, int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int color_o();
        return int'({red, green, blue});
    endfunction

    task automatic check_all(string tag);
        check({tag, " color"}, color_o(), m_color);
        check({tag, " ghost_x"}, int'(gx_o), m_gx);
        check({tag, " ghost_y"}, int'(gy_o), m_gy);
        check({tag, " anim"}, int'(anim_o), m_frame);
    endtask

    task automatic strobes(int n);
        hc = 10'd0; vc = 10'd480;
        repeat (n) tick();
    endtask

    // Output after the edge belongs to pixel (h,v) when (h-1,v) is driven
    task automatic show_pixel(int h, int v);
        hc = 10'(h - 1); vc = 10'(v);
        tick();
    endtask

    initial begin
        int h, v;
        model_reset();
        rst_n = 1'b0; pause = 1'b0; hc = 10'd100; vc = 10'd100;
        repeat (5) tick();
        check("reset color", color_o(), 0);
        check("reset gx", int'(gx_o), 0);
        check("reset gy", int'(gy_o), 0);
        check("reset anim", int'(anim_o), 0);

        rst_n = 1'b1;
        strobes(3);
        check("motion gx", int'(gx_o), 6);
        check("motion gy", int'(gy_o), 3);
        show_pixel(50, 50);
        check("bg pixel", color_o(), 'h03);

        strobes(11);
        check("anim 14", int'(anim_o), 0);
        strobes(1);
        check("anim 15", int'(anim_o), 1);

        pause = 1'b1;
        strobes(3);
        check("pause gx", int'(gx_o), 30);
        check("pause gy", int'(gy_o), 15);
        check("pause anim", int'(anim_o), 1);
        for (int i = 0; i < 20; i++) begin
            pause = 1'(i % 2);
            hc = 10'($urandom_range(1, 799)); vc = 10'($urandom_range(0, 524));
            tick();
        end
        check_all("pause off-strobe");
        check("pause off-strobe gx", int'(gx_o), 30);

        pause = 1'b0;
        strobes(35);
        check("pos gx", int'(gx_o), 100);
        check("pos gy", int'(gy_o), 50);
        show_pixel(102, 66);  check("body", color_o(), 'hE0);
        show_pixel(100, 50);  check("transparent", color_o(), 'h03);
        show_pixel(108, 60);  check("eye", color_o(), 'hFF);
        show_pixel(108, 62);  check("pupil f1", color_o(), 'h03);
        show_pixel(110, 62);  check("eye f1", color_o(), 'hFF);
        show_pixel(640, 66);  check("offscreen", color_o(), 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                pause = ($urandom_range(0, 4) == 0);
                hc = 10'd0; vc = 10'd480;
            end else begin
                pause = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 0) begin
                    h = m_gx + int'($urandom_range(0, 34)) - 2;
                    v = m_gy + int'($urandom_range(0, 34)) - 1;
                    if (h < 0) h = 0;
                    if (v < 0) v = 0;
                end else begin
                    h = int'($urandom_range(0, 799));
                    v = int'($urandom_range(0, 524));
                end
                if (h == 0 && v == 480) v = 479;
                hc = 10'(h); vc = 10'(v);
            end
            tick();
            check_all("random");
        end

        hc = 10'd300; vc = 10'd200; pause = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_all("midreset 1");
        check("midreset color", color_o(), 0);
        hc = 10'd301;
        tick();
        check_all("midreset 2");
        rst_n = 1'b1;
        show_pixel(10, 10);
        check("after reset eye", color_o(), 'hFF);
        check("after reset gx", int'(gx_o), 0);
        hc = 10'd799; vc = 10'd524;
        tick();
        check_all("wrap");
        check("wrap color", color_o(), 'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
